// File: rtl/priority_seg_scan_if.sv
// +----------------------------------------------------------------------+
// | priority_seg_scan_if : request/capture and display bus for the scan  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface priority_seg_scan_if #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 4
);
    logic [IN_W-1:0]   a;
    logic              load;
    logic              clr;
    logic [3:0]        code;
    logic [7:0]        seg;
    logic [DIGITS-1:0] en;

    modport master (
        output a, load, clr,
        input  code, seg, en
    );

    modport slave (
        input  a, load, clr,
        output code, seg, en
    );
endinterface

`default_nettype wire

// File: rtl/priority_seg_scan.sv
// +----------------------------------------------------------------------+
// | priority_seg_scan : priority encoder feeding a multiplexed 7-segment |
// | history display. Rev 1.0                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module priority_seg_scan #(
    parameter int IN_W     = 8,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  wire                   clk,
    input  wire                   rst,
    priority_seg_scan_if.slave    bus
);
    localparam int c_PC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [c_PC_W-1:0]  r_pc;
    logic [c_IDX_W-1:0] r_idx;
    logic [3:0]         r_slot [DIGITS];
    logic [DIGITS-1:0]  r_vld;
    logic [3:0]         r_code;
    logic [7:0]         r_seg;
    logic [DIGITS-1:0]  r_en;

    logic [3:0]         w_code;
    logic [7:0]         w_seg;

    function automatic logic [7:0] font(input logic [3:0] c);
        case (c)
            4'h0: font = 8'h03;
            4'h1: font = 8'h9F;
            4'h2: font = 8'h25;
            4'h3: font = 8'h0D;
            4'h4: font = 8'h99;
            4'h5: font = 8'h49;
            4'h6: font = 8'h41;
            4'h7: font = 8'h1F;
            4'h8: font = 8'h01;
            4'h9: font = 8'h19;
            4'hA: font = 8'h11;
            4'hB: font = 8'hC1;
            4'hC: font = 8'h63;
            4'hD: font = 8'h85;
            4'hE: font = 8'h61;
            default: font = 8'h71;
        endcase
    endfunction

    // Ascending scan so the highest set line wins.
    always_comb begin
        w_code = 4'd0;
        for (int i = 0; i < IN_W; i++) begin
            if (bus.a[i]) begin
                w_code = 4'(i + 1);
            end
        end
    end

    // Newest entry (digit 0) gets its decimal point lit.
    always_comb begin
        w_seg = 8'hFF;
        if (r_vld[r_idx]) begin
            w_seg = font(r_slot[r_idx]);
            if (r_idx == '0) begin
                w_seg[0] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= '0;
            r_idx  <= '0;
            r_vld  <= '0;
            r_code <= 4'd0;
            r_seg  <= 8'hFF;
            r_en   <= ~DIGITS'(1);
            for (int k = 0; k < DIGITS; k++) begin
                r_slot[k] <= 4'd0;
            end
        end else begin
            r_seg <= w_seg;
            r_en  <= ~(DIGITS'(1) << r_idx);

            if (r_pc == c_PC_W'(SCAN_DIV - 1)) begin
                r_pc <= '0;
                if (r_idx == c_IDX_W'(DIGITS - 1)) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end else begin
                r_pc <= r_pc + 1'b1;
            end

            if (bus.clr) begin
                r_vld  <= '0;
                r_code <= 4'd0;
                for (int k = 0; k < DIGITS; k++) begin
                    r_slot[k] <= 4'd0;
                end
            end else if (bus.load) begin
                r_code    <= w_code;
                r_slot[0] <= w_code;
                r_vld[0]  <= 1'b1;
                for (int k = 1; k < DIGITS; k++) begin
                    r_slot[k] <= r_slot[k-1];
                    r_vld[k]  <= r_vld[k-1];
                end
            end
        end
    end

    assign bus.code = r_code;
    assign bus.seg  = r_seg;
    assign bus.en   = r_en;
endmodule

`default_nettype wire

// File: tb/tb_priority_seg_scan.sv
// +----------------------------------------------------------------------+
// | tb_priority_seg_scan : randomized and directed bench for the scan    |
// | display against a queue-based reference model. Rev 1.0               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_priority_seg_scan;
    localparam int c_IN_W = 8;
    localparam int c_DIG  = 4;
    localparam int c_DIV  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    priority_seg_scan_if #(.IN_W(c_IN_W), .DIGITS(c_DIG)) bus ();

    priority_seg_scan #(
        .IN_W(c_IN_W), .DIGITS(c_DIG), .SCAN_DIV(c_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] c_font [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                8'h01, 8'h19, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    int checks   = 0;
    int failures = 0;

    // Reference model: cycles since reset plus a newest-first list of codes.
    int         n_cyc = 0;
    int         hist[$];
    int         m_code = 0;
    logic [7:0] m_seg = 8'hFF;
    logic [c_DIG-1:0] m_en = ~c_DIG'(1);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int enc(input logic [c_IN_W-1:0] v);
        return $clog2(int'(v) + 1);
    endfunction

    task automatic step(input logic r, input logic ld, input logic cl, input logic [c_IN_W-1:0] av);
        int d;
        int zeros;
        @(negedge clk);
        rst = r; bus.load = ld; bus.clr = cl; bus.a = av;
        @(posedge clk);
        if (r) begin
            m_seg = 8'hFF; m_en = ~c_DIG'(1); n_cyc = 0; hist.delete(); m_code = 0;
        end else begin
            d = (n_cyc / c_DIV) % c_DIG;
            m_en = ~(c_DIG'(1) << d);
            if (d < hist.size()) begin
                m_seg = c_font[hist[d]];
                if (d == 0) m_seg[0] = 1'b0;
            end else begin
                m_seg = 8'hFF;
            end
            n_cyc++;
            if (cl) begin
                hist.delete(); m_code = 0;
            end else if (ld) begin
                m_code = enc(av);
                hist.push_front(m_code);
                if (hist.size() > c_DIG) void'(hist.pop_back());
            end
        end
        #1;
        check("seg", 32'(bus.seg), 32'(m_seg));
        check("en", 32'(bus.en), 32'(m_en));
        check("code", 32'(bus.code), 32'(m_code));
        zeros = 0;
        for (int i = 0; i < c_DIG; i++) if (!bus.en[i]) zeros++;
        check("en_onehot", 32'(zeros), 32'd1);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic push(input logic [c_IN_W-1:0] av);
        step(1'b0, 1'b1, 1'b0, av);
    endtask

    initial begin
        logic [c_IN_W-1:0] prio_pat [5];
        logic [31:0]       prio_exp [5];
        logic [c_IN_W-1:0] hist_pat [5];
        bit                hit;
        prio_pat = '{8'h00, 8'h01, 8'h24, 8'hFF, 8'h80};
        prio_exp = '{32'd0, 32'd1, 32'd6, 32'd8, 32'd8};
        hist_pat = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        bus.a = '0; bus.load = 1'b0; bus.clr = 1'b0;

        // Reset and idle scan with blank display.
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        check("rst_seg", 32'(bus.seg), 32'hFF);
        check("rst_en", 32'(bus.en), 32'hE);
        check("rst_code", 32'(bus.code), 32'h0);
        idle(20);

        // Priority encoding, each followed by a full frame.
        for (int i = 0; i < 5; i++) begin
            push(prio_pat[i]);
            check("prio_code", 32'(bus.code), prio_exp[i]);
            idle(c_DIG * c_DIV);
        end

        // History shift.
        for (int i = 0; i < 5; i++) push(hist_pat[i]);
        idle(2 * c_DIG * c_DIV);

        // Partial fill.
        step(1'b1, 1'b0, 1'b0, '0);
        push(8'h40);
        idle(2 * c_DIG * c_DIV);

        // Clear overrides a simultaneous load.
        for (int i = 0; i < 4; i++) push(8'(1 << i));
        step(1'b0, 1'b1, 1'b1, 8'h80);
        check("clr_code", 32'(bus.code), 32'h0);
        idle(2 * c_DIG * c_DIV);

        // Mid-operation reset at idx=2, pc=1.
        hit = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            if (((n_cyc / c_DIV) % c_DIG) == 2 && (n_cyc % c_DIV) == 1) hit = 1'b1;
            else push(8'($urandom));
        end
        check("midrst_reached", 32'(hit), 32'd1);
        step(1'b1, 1'b0, 1'b0, '0);
        check("midrst_en", 32'(bus.en), 32'hE);
        idle(c_DIG * c_DIV + 3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 29) == 0,
                 8'($urandom >> $urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/priority_seg_scan.md
# priority_seg_scan

Parametrised priority encoder with a multiplexed, multi-digit seven-segment display. On each `load` strobe the block priority-encodes the input lines and pushes the code into a DIGITS-deep history: digit 0 holds the newest code and older codes shift toward higher digits. A prescaled scan counter time-multiplexes the history onto a shared active-low segment bus with active-low digit enables. It sits between the board switch/key inputs and the seven-segment display pins.

## Interface
Parameters:
- `IN_W`, 8: number of input lines, 1..15.
- `DIGITS`, 4: number of display digits and history slots, 1..8.
- `SCAN_DIV`, 50000: clock cycles per digit dwell, ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a`  in  IN_W  request lines; `a[i]` encodes to code i+1.
- `load`  in  1  capture strobe, sampled each clock.
- `clr`  in  1  synchronous history clear.
- `code`  out  4  most recently captured code (registered).
- `seg`  out  8  segments {a,b,c,d,e,f,g,dp}, active-low, registered.
- `en`  out  DIGITS  digit enables, active-low one-hot, registered.

## Operation
- Priority encode: code = (index of highest set bit of `a`) + 1; 0 when `a` is all zero. Combinational, sampled only when `load`=1.
- History: `slot[0..DIGITS-1]` (4 bits each) plus a `vld` bit per slot.
- On `load`: `slot[0]` ← code, `slot[k]` ← `slot[k-1]`, `vld[0]` ← 1, `vld[k]` ← `vld[k-1]`, and `code` ← code. The oldest entry is discarded.
- `clr`: all `slot` ← 0, all `vld` ← 0, `code` ← 0. `clr` overrides a `load` in the same cycle. The scan counter is unaffected.
- Priority order: `rst` > `clr` > `load`.
- Scan:
  - Prescaler `pc` counts 0..SCAN_DIV-1.
  - When `pc` = SCAN_DIV-1, `pc` ← 0 and digit index `idx` ← (`idx`+1) mod DIGITS. Wrap goes from DIGITS-1 to 0.
  - When SCAN_DIV=1, `idx` advances every cycle.
- Font (code → `seg`, hex):
  - 0:03, 1:9F, 2:25, 3:0D, 4:99, 5:49, 6:41, 7:1F
  - 8:01, 9:19, A:11, B:C1, C:63, D:85, E:61, F:71
- Blanking: a slot with `vld`=0 drives `seg`=FF.
- Decimal point: when digit 0 is shown and `vld[0]`=1, `seg[0]` is forced to 0 (dp lit), marking the newest entry.
- Codes 0..15 are all legal. IN_W ≤ 15 guarantees codes ≤ 15.

## Timing
- Reset values:
  - `pc`=0, `idx`=0, all `slot`=0, all `vld`=0, `code`=0.
  - `en` = all ones except bit 0 (e.g. 1110 for DIGITS=4).
  - `seg` = FF.
- Output registration: `seg` and `en` update together each cycle from the pre-edge `idx`, `slot` and `vld`:
  - `en`(t+1) = ~(1 << `idx`(t)).
  - `seg`(t+1) = font/blank/dp of `slot[idx(t)]` as held at t.
- Capture latency: `load` high at edge t updates `code` at t and `slot` at t. The new value appears on `seg` at edge t+1 if digit 0 is being scanned then; otherwise it appears when `idx` next reaches 0.
- Dwell: each digit is enabled for exactly SCAN_DIV consecutive cycles. A full frame is DIGITS×SCAN_DIV cycles.
- Exactly one `en` bit is low at all times, including during reset.
- `rst` mid-scan forces the reset values on the next edge, whatever the `pc` or `idx` value.
- `load` held high for N cycles performs N pushes, one per cycle.
- `load` on the same cycle as a prescaler wrap: both take effect. Output follows the registration rule above.
- `clr` and `load` together: the history is cleared and nothing is pushed.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4, IN_W=8.
- Reset: assert `rst` for 2 cycles → `seg`=FF, `en`=1110, `code`=0.
  - After release, `en` steps 1110→1101→1011→0111→1110 every 4 cycles.
  - `seg` stays FF throughout.
- Priority: `a`=0x00, `load` → `code`=0; when digit 0 is shown, `seg`=02 (font 03 with dp lit).
  - `a`=0x01 → `code`=1.
  - `a`=0x24 → `code`=6.
  - `a`=0xFF → `code`=8.
  - `a`=0x80 → `code`=8.
- History shift: load codes 1, 2, 3, 4, 5 (`a`=0x01, 0x02, 0x04, 0x08, 0x10) in that order.
  - Over one frame, `seg` for digits 0..3 = 48 (5 with dp), 99, 0D, 25.
  - Code 1 has been discarded.
- Partial fill: after reset, load one code 7 (`a`=0x40) → digit 0 shows 1E; digits 1..3 show FF.
- Clear: fill the history, then assert `clr` and `load` together with `a`=0x80 → all digits FF and `code`=0 from the next frame on.
- Mid-operation reset: `rst` while `idx`=2 and `pc`=1 → next edge restores all reset values. The scan restarts at digit 0 with a full 4-cycle dwell.
